// File: rtl/uart_periph_if.sv
// uart_periph_if: CPU data-bus signals shared by the data memory and the
// UART peripheral. The CPU side drives the strobes, address and write data;
// the peripheral returns combinational read data.
interface uart_periph_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output MemRead,
    output MemWrite,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  MemRead,
    input  MemWrite,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/uart_periph.sv
// uart_periph: memory-mapped UART for the single-cycle MIPS CPU.
//   TXD 0x4000_0018, RXD 0x4000_001C, CON 0x4000_0020.
// Optional feature macro: UART_PARITY_EN adds an even parity bit after the
// data bits (TX generates it, RX checks it). Without it frames are 8N1.
module uart_periph #(
  parameter int BAUD_DIV = 5208
) (
  input  logic         clk,
  input  logic         rst,
  uart_periph_if.slave bus,
  input  logic         rx,
  output logic         tx,
  output logic         irq
);

  localparam logic [31:0] ADDR_TXD  = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD  = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON  = 32'h4000_0020;
  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

  // Bus decode: exact 32-bit match only.
  logic sel_txd, sel_rxd, sel_con;
  logic wr_txd, wr_con, rd_rxd, rd_con;

  assign sel_txd = (bus.addr == ADDR_TXD);
  assign sel_rxd = (bus.addr == ADDR_RXD);
  assign sel_con = (bus.addr == ADDR_CON);
  assign wr_txd  = bus.MemWrite & sel_txd;
  assign wr_con  = bus.MemWrite & sel_con;
  assign rd_rxd  = bus.MemRead  & sel_rxd;
  assign rd_con  = bus.MemRead  & sel_con;

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:8];

  // Software-visible registers and flags.
  logic [7:0] txd_reg, rxd_reg;
  logic       tx_irq_en, rx_irq_en;
  logic       tx_done, rx_valid, overrun, frame_err, parity_err;
  logic       tx_busy;

  // ---------------- TX path ----------------
  tx_state_t   tx_state, tx_state_nx;
  logic [15:0] tx_cnt, tx_cnt_nx;
  logic [2:0]  tx_bit, tx_bit_nx;
  logic        tx_line, tx_line_nx;
  logic        tx_accept, tx_finish, tx_tick;

  assign tx_tick = (tx_cnt == BIT_LAST);
  assign tx_busy = (tx_state != TX_IDLE);

  // TX state register; the line flop resets high so tx idles at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bit   <= tx_bit_nx;
      tx_line  <= tx_line_nx;
    end
  end

  // TX next-state, bit timing and serial line value for the current state.
  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_bit_nx   = tx_bit;
    tx_line_nx  = 1'b1;
    tx_accept   = 1'b0;
    tx_finish   = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (wr_txd) begin
          tx_accept   = 1'b1;
          tx_state_nx = TX_START;
          tx_cnt_nx   = '0;
          tx_bit_nx   = '0;
        end
      end
      TX_START: begin
        tx_line_nx = 1'b0;
        if (tx_tick) begin
          tx_cnt_nx   = '0;
          tx_state_nx = TX_DATA;
        end else begin
          tx_cnt_nx = tx_cnt + 16'd1;
        end
      end
      TX_DATA: begin
        tx_line_nx = txd_reg[tx_bit];
        if (tx_tick) begin
          tx_cnt_nx = '0;
          if (tx_bit == 3'd7) begin
            tx_bit_nx   = '0;
`ifdef UART_PARITY_EN
            tx_state_nx = TX_PARITY;
`else
            tx_state_nx = TX_STOP;
`endif
          end else begin
            tx_bit_nx = tx_bit + 3'd1;
          end
        end else begin
          tx_cnt_nx = tx_cnt + 16'd1;
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        tx_line_nx = even_parity(txd_reg);
        if (tx_tick) begin
          tx_cnt_nx   = '0;
          tx_state_nx = TX_STOP;
        end else begin
          tx_cnt_nx = tx_cnt + 16'd1;
        end
      end
`endif
      TX_STOP: begin
        tx_line_nx = 1'b1;
        if (tx_tick) begin
          tx_cnt_nx   = '0;
          tx_state_nx = TX_IDLE;
          tx_finish   = 1'b1;
        end else begin
          tx_cnt_nx = tx_cnt + 16'd1;
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  assign tx = tx_line;

  // ---------------- RX path ----------------
  logic        rx_sync1, rx_sync2, rx_prev, rx_fall;
  rx_state_t   rx_state, rx_state_nx;
  logic [15:0] rx_cnt, rx_cnt_nx;
  logic [2:0]  rx_bit, rx_bit_nx;
  logic [7:0]  rx_shift, rx_shift_nx;
  logic        rx_ok, rx_ferr, rx_tick;
`ifdef UART_PARITY_EN
  logic        rx_par, rx_par_nx, rx_perr;
`endif

  assign rx_fall = rx_prev & ~rx_sync2;
  assign rx_tick = (rx_cnt == BIT_LAST);

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= rx;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
    end
  end

  // RX state register and receive shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
`ifdef UART_PARITY_EN
      rx_par   <= 1'b0;
`endif
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
      rx_shift <= rx_shift_nx;
`ifdef UART_PARITY_EN
      rx_par   <= rx_par_nx;
`endif
    end
  end

  // RX next-state: mid-start qualification, mid-bit sampling, frame verdict.
  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_ok       = 1'b0;
    rx_ferr     = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_nx   = rx_par;
    rx_perr     = 1'b0;
`endif
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_nx = RX_START;
          rx_cnt_nx   = '0;
          rx_bit_nx   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nx   = '0;
          rx_state_nx = rx_sync2 ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_nx = rx_cnt + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_cnt_nx   = '0;
          rx_shift_nx = {rx_sync2, rx_shift[7:1]};
          if (rx_bit == 3'd7) begin
            rx_bit_nx   = '0;
`ifdef UART_PARITY_EN
            rx_state_nx = RX_PARITY;
`else
            rx_state_nx = RX_STOP;
`endif
          end else begin
            rx_bit_nx = rx_bit + 3'd1;
          end
        end else begin
          rx_cnt_nx = rx_cnt + 16'd1;
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_tick) begin
          rx_cnt_nx   = '0;
          rx_par_nx   = rx_sync2;
          rx_state_nx = RX_STOP;
        end else begin
          rx_cnt_nx = rx_cnt + 16'd1;
        end
      end
`endif
      RX_STOP: begin
        if (rx_tick) begin
          rx_cnt_nx   = '0;
          rx_state_nx = RX_IDLE;
          if (!rx_sync2) begin
            rx_ferr = 1'b1;
`ifdef UART_PARITY_EN
          end else if (even_parity(rx_shift) != rx_par) begin
            rx_perr = 1'b1;
`endif
          end else begin
            rx_ok = 1'b1;
          end
        end else begin
          rx_cnt_nx = rx_cnt + 16'd1;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  // ---------------- Registers and flags ----------------
  // Flag set has priority over read-side clears; CON writes touch enables only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txd_reg   <= '0;
      rxd_reg   <= '0;
      tx_irq_en <= 1'b0;
      rx_irq_en <= 1'b0;
      tx_done   <= 1'b0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (tx_accept) txd_reg <= bus.wdata[7:0];
      if (wr_con) begin
        tx_irq_en <= bus.wdata[0];
        rx_irq_en <= bus.wdata[1];
      end
      if (tx_finish)   tx_done <= 1'b1;
      else if (rd_con) tx_done <= 1'b0;
      if (rx_ok)       rx_valid <= 1'b1;
      else if (rd_rxd) rx_valid <= 1'b0;
      if (rx_ok && rx_valid) overrun <= 1'b1;
      else if (rd_con)       overrun <= 1'b0;
      if (rx_ferr)     frame_err <= 1'b1;
      else if (rd_con) frame_err <= 1'b0;
      if (rx_ok) rxd_reg <= rx_shift;
    end
  end

`ifdef UART_PARITY_EN
  // Sticky parity error, cleared by a CON read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         parity_err <= 1'b0;
    else if (rx_perr) parity_err <= 1'b1;
    else if (rd_con)  parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
`endif

  assign irq = (tx_irq_en & tx_done) | (rx_irq_en & rx_valid);

  logic [31:0] rdata_c;

  // Combinational read mux; zero unless this block is addressed by a read.
  always_comb begin
    rdata_c = '0;
    if (bus.MemRead) begin
      if (sel_txd)      rdata_c = {24'h0, txd_reg};
      else if (sel_rxd) rdata_c = {24'h0, rxd_reg};
      else if (sel_con) rdata_c = {24'h0, parity_err, frame_err, overrun, tx_busy,
                                   rx_valid, tx_done, rx_irq_en, tx_irq_en};
    end
  end

  assign bus.rdata = rdata_c;

endmodule

// File: doc/uart_periph.md
# uart_periph

Memory-mapped UART for the single-cycle MIPS CPU. It sits beside the data memory on the same address/data bus and drives the board's `rx`/`tx` pins. It decodes three word addresses in the 0x4000_00xx peripheral window, returns read data combinationally, and raises `irq` on transmit-done or receive-valid events. The data memory returns 0 for these addresses; the system read mux ORs the two `rdata` buses.

## Interface
- `BAUD_DIV`, 5208: clock cycles per bit (50 MHz / 9600 baud); legal range 4..65535.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; asserted while 0.
- `MemRead`  in  1  bus read strobe.
- `MemWrite`  in  1  bus write strobe.
- `addr`  in  32  byte address.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; combinational; 0 when not selected.
- `rx`  in  1  serial input; asynchronous to `clk`.
- `tx`  out  1  serial output; idles high.
- `irq`  out  1  level interrupt request.

## Operation
- Register map. The full 32-bit address must match exactly.
  - TXD 0x4000_0018: write bits [7:0] to start a transmission. Reads return the last accepted byte in [7:0].
  - RXD 0x4000_001C: reads return the last received byte in [7:0]. A read clears `rx_valid`.
  - CON 0x4000_0020 bit fields:
    - [0] `tx_irq_en`, read/write.
    - [1] `rx_irq_en`, read/write.
    - [2] `tx_done`, read-only, sticky.
    - [3] `rx_valid`, read-only.
    - [4] `tx_busy`, read-only.
    - [5] `overrun`, read-only, sticky.
    - [6] `frame_err`, read-only, sticky.
    - [7] `parity_err`, read-only, sticky.
    - [31:8] read as 0.
  - A write to CON updates [1:0] only.
  - A read of CON clears [2], [5], [6] and [7].
- Read side effects take place on the clock edge where `MemRead` is high and the address matches. `rdata` shows the pre-clear value during that cycle.
- `irq` = (`tx_irq_en` & `tx_done`) | (`rx_irq_en` & `rx_valid`). It is a registered-flag combination and is never pulsed.
- TX state machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Each state lasts `BAUD_DIV` cycles. DATA sends 8 bits, LSB first.
  - A TXD write in IDLE latches the byte and sets `tx_busy`.
  - A TXD write while busy is ignored: the byte is not latched and no flag changes.
  - At the end of STOP: `tx_busy` drops and `tx_done` is set.
- RX path:
  - `rx` passes through a 2-flop synchronizer.
  - IDLE waits for a 1->0 transition, then counts `BAUD_DIV/2` cycles (integer division) to reach mid-start.
  - If the line is high at mid-start, the event is a false start: return to IDLE with no flag change.
  - Otherwise sample 8 data bits, [parity], and the stop bit, one every `BAUD_DIV` cycles.
- RX result at the mid-stop sample:
  - Stop bit = 0: set `frame_err` and discard the byte.
  - Parity mismatch: set `parity_err` and discard the byte.
  - Otherwise, if `rx_valid` is already set, set `overrun`. Then overwrite RXD and set `rx_valid`.
  - After the mid-stop sample, RX returns to IDLE immediately; the next start bit may follow.
- Simultaneous events:
  - Flag set and flag clear in the same cycle: set wins. This covers an RX completion coinciding with an RXD read, and `tx_done` set coinciding with a CON read.
  - A CON write coinciding with a flag update: both take effect.

## Timing
- Reset values: `tx`=1, `irq`=0, all registers and flags 0, both FSMs IDLE, bit counters 0.
- `rdata` is 0 whenever `MemRead`=0. Otherwise it is combinational from `addr` and the registers.
- TX latency: a TXD write sampled at edge k drives `tx` low from edge k+1. The start bit lasts exactly `BAUD_DIV` cycles.
- Frame length: 10·`BAUD_DIV` cycles, or 11·`BAUD_DIV` with parity. `tx_done` is set on the edge ending STOP.
- RX latency: `rx_valid` is set 2 + `BAUD_DIV/2` + 9·`BAUD_DIV` cycles (+`BAUD_DIV` with parity) after the falling edge reaches the synchronizer input. Tolerance is ±1 cycle for the synchronizer phase.
- Reset mid-frame aborts both FSMs immediately: `tx` returns to 1 asynchronously and the partial RX byte is lost.

## Configuration
- `UART_PARITY_EN` defined: an even parity bit is inserted after the data bits. TX generates it and RX checks it. Mismatches set `parity_err` and discard the byte.
- `UART_PARITY_EN` undefined: frames are 8N1 with no parity state, and CON[7] reads 0.

## Test plan
All scenarios use `BAUD_DIV`=16 unless noted.

- **Reset:** hold `rst`=0 with `rx`=1.
  - Then `tx`=1 and `irq`=0.
  - A read of CON with `MemRead`=1 returns 0x0000_0000.
- **TX frame:** write 0x0000_00A5 to 0x4000_0018.
  - `tx` goes low at the next edge, then carries bits 1,0,1,0,0,1,0,1 at 16-cycle spacing, then a high stop bit.
  - `tx_busy` is high for 160 cycles, then `tx_done`=1.
  - With CON=0x1 written beforehand, `irq`=1. A CON read clears it.
- **Busy write:** write 0x3C during a TX of 0x55.
  - The serial output carries 0x55 only.
  - A TXD read returns 0x55.
- **RX byte:** drive an 8N1 frame of 0xC3 on `rx` with `rx_irq_en`=1.
  - `rx_valid`=1 and `irq`=1.
  - An RXD read returns 0xC3, and the next cycle shows `rx_valid`=0 and `irq`=0.
- **Error cases:**
  - Two frames with no RXD read in between set `overrun`; RXD holds the second byte.
  - A frame with stop=0 sets `frame_err` and leaves RXD unchanged.
  - A 4-cycle low glitch is rejected as a false start with no flag change.
- **Boundary:**
  - `rx_valid` completes on the same edge as an RXD read: `rx_valid` stays 1.
  - `rst` pulsed low mid-TX: `tx` goes to 1 immediately, and a subsequent TXD write succeeds.
